// File: rtl/setting_ctrl.sv
// Game configuration editor: turns debounced button levels into item navigation
// and single-step / auto-repeat edits of six wrapped configuration values.
module setting_ctrl #(
  parameter int MAX_PLAYERS   = 4,
  parameter int MAX_QUESTIONS = 9,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] view,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_confirm,
  output logic [2:0] state,
  output logic [2:0] player_count,
  output logic [3:0] question_count,
  output logic [6:0] answer_time,
  output logic [6:0] win_score,
  output logic [3:0] success_score,
  output logic [3:0] fail_score,
  output logic       cfg_done
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [7:0] PL_MAX = 8'(MAX_PLAYERS);
  localparam logic [7:0] QU_MAX = 8'(MAX_QUESTIONS);

  typedef enum logic [1:0] {R_IDLE, R_HOLD, R_REPEAT} rep_t;

  rep_t             rep_state, rep_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             held_dec, held_next;

  logic btn_next_q, btn_prev_q, btn_inc_q, btn_dec_q, btn_confirm_q;
  logic edit_en;
  logic press_next, press_prev, press_inc, press_dec, press_confirm;
  logic nav_press, held_lvl, held_active, start_inc, start_dec;
  logic tick_hold, tick_rep;
  logic step_en, step_up;

  // Values are widened by one bit so +1 at the top of a 7-bit range cannot overflow.
  function automatic logic [7:0] wrap_step(input logic [7:0] v, input logic up,
                                           input logic [7:0] lo, input logic [7:0] hi);
    logic [7:0] r;
    if (up) r = (v >= hi) ? lo : v + 8'd1;
    else    r = (v <= lo) ? hi : v - 8'd1;
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_next_q    <= 1'b0;
      btn_prev_q    <= 1'b0;
      btn_inc_q     <= 1'b0;
      btn_dec_q     <= 1'b0;
      btn_confirm_q <= 1'b0;
    end else begin
      btn_next_q    <= btn_next;
      btn_prev_q    <= btn_prev;
      btn_inc_q     <= btn_inc;
      btn_dec_q     <= btn_dec;
      btn_confirm_q <= btn_confirm;
    end
  end

  assign edit_en       = (view == 3'd0);
  assign press_next    = edit_en & btn_next    & ~btn_next_q;
  assign press_prev    = edit_en & btn_prev    & ~btn_prev_q;
  assign press_inc     = edit_en & btn_inc     & ~btn_inc_q;
  assign press_dec     = edit_en & btn_dec     & ~btn_dec_q;
  assign press_confirm = edit_en & btn_confirm & ~btn_confirm_q;

  assign nav_press   = press_confirm | press_next | press_prev;
  assign held_lvl    = held_dec ? btn_dec : btn_inc;
  // While a repeat is live, a press of the opposite button is dropped.
  assign held_active = (rep_state != R_IDLE) && held_lvl;
  assign start_inc   = !nav_press && !held_active && press_inc;
  assign start_dec   = !nav_press && !held_active && !press_inc && press_dec;
  assign tick_hold   = (rep_state == R_HOLD)   && (cnt == DELAY_LAST);
  assign tick_rep    = (rep_state == R_REPEAT) && (cnt == PERIOD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_state <= R_IDLE;
      cnt       <= '0;
      held_dec  <= 1'b0;
    end else begin
      rep_state <= rep_next;
      cnt       <= cnt_next;
      held_dec  <= held_next;
    end
  end

  always_comb begin
    rep_next  = rep_state;
    cnt_next  = cnt;
    held_next = held_dec;
    if (!edit_en || nav_press) begin
      rep_next = R_IDLE;
      cnt_next = '0;
    end else if (start_inc || start_dec) begin
      rep_next  = R_HOLD;
      cnt_next  = '0;
      held_next = start_dec;
    end else begin
      case (rep_state)
        R_HOLD, R_REPEAT: begin
          if (!held_lvl) begin
            rep_next = R_IDLE;
            cnt_next = '0;
          end else if (tick_hold || tick_rep) begin
            rep_next = R_REPEAT;
            cnt_next = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: begin
          rep_next = R_IDLE;
          cnt_next = '0;
        end
      endcase
    end
  end

  always_comb begin
    step_en = 1'b0;
    step_up = 1'b0;
    if (edit_en && !nav_press) begin
      if (start_inc || start_dec) begin
        step_en = 1'b1;
        step_up = start_inc;
      end else if (held_active && (tick_hold || tick_rep)) begin
        step_en = 1'b1;
        step_up = !held_dec;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= 3'd0;
      player_count   <= 3'd2;
      question_count <= 4'd5;
      answer_time    <= 7'd30;
      win_score      <= 7'd10;
      success_score  <= 4'd1;
      fail_score     <= 4'd1;
      cfg_done       <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      if (press_confirm) begin
        state    <= 3'd0;
        cfg_done <= 1'b1;
      end else if (press_next) begin
        state <= (state == 3'd6) ? 3'd0 : state + 3'd1;
      end else if (press_prev) begin
        state <= (state == 3'd0) ? 3'd6 : state - 3'd1;
      end else if (step_en) begin
        case (state)
          3'd1: player_count   <= 3'(wrap_step({5'd0, player_count}, step_up, 8'd1, PL_MAX));
          3'd2: question_count <= 4'(wrap_step({4'd0, question_count}, step_up, 8'd1, QU_MAX));
          3'd3: answer_time    <= 7'(wrap_step({1'b0, answer_time}, step_up, 8'd5, 8'd99));
          3'd4: win_score      <= 7'(wrap_step({1'b0, win_score}, step_up, 8'd1, 8'd99));
          3'd5: success_score  <= 4'(wrap_step({4'd0, success_score}, step_up, 8'd1, 8'd9));
          3'd6: fail_score     <= 4'(wrap_step({4'd0, fail_score}, step_up, 8'd0, 8'd9));
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_setting_ctrl.sv
// Directed bench for setting_ctrl: a reference model pushes expected snapshots
// into a queue as stimulus is driven; they are popped and compared after each edge.
module tb_setting_ctrl;
  localparam int MAXP = 4;
  localparam int MAXQ = 9;
  localparam int RD   = 10;
  localparam int RP   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] view;
  logic       btn_next, btn_prev, btn_inc, btn_dec, btn_confirm;
  logic [2:0] state;
  logic [2:0] player_count;
  logic [3:0] question_count;
  logic [6:0] answer_time;
  logic [6:0] win_score;
  logic [3:0] success_score;
  logic [3:0] fail_score;
  logic       cfg_done;

  setting_ctrl #(
    .MAX_PLAYERS(MAXP), .MAX_QUESTIONS(MAXQ), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .view(view),
    .btn_next(btn_next), .btn_prev(btn_prev), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .btn_confirm(btn_confirm),
    .state(state), .player_count(player_count), .question_count(question_count),
    .answer_time(answer_time), .win_score(win_score), .success_score(success_score),
    .fail_score(fail_score), .cfg_done(cfg_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int st, pc, qc, at, ws, ss, fs, cd;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int ms, mpc, mqc, mat, mws, mss, mfs;

  function automatic int wrapm(int v, int lo, int hi, bit up);
    int n = hi - lo + 1;
    return up ? lo + ((v - lo + 1) % n) : lo + ((v - lo + n - 1) % n);
  endfunction

  task automatic m_reset();
    ms = 0; mpc = 2; mqc = 5; mat = 30; mws = 10; mss = 1; mfs = 1;
  endtask

  task automatic m_step(bit up);
    case (ms)
      1: mpc = wrapm(mpc, 1, MAXP, up);
      2: mqc = wrapm(mqc, 1, MAXQ, up);
      3: mat = wrapm(mat, 5, 99, up);
      4: mws = wrapm(mws, 1, 99, up);
      5: mss = wrapm(mss, 1, 9, up);
      6: mfs = wrapm(mfs, 0, 9, up);
      default: ;
    endcase
  endtask

  task automatic push(string tag, int cd);
    exp_t e;
    e.tag = tag; e.st = ms; e.pc = mpc; e.qc = mqc; e.at = mat;
    e.ws = mws; e.ss = mss; e.fs = mfs; e.cd = cd;
    sb.push_back(e);
  endtask

  task automatic cmp(string tag, string f, int obs, int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, f, obs, expv);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp(e.tag, "state", int'(state), e.st);
      cmp(e.tag, "player", int'(player_count), e.pc);
      cmp(e.tag, "question", int'(question_count), e.qc);
      cmp(e.tag, "time", int'(answer_time), e.at);
      cmp(e.tag, "win", int'(win_score), e.ws);
      cmp(e.tag, "success", int'(success_score), e.ss);
      cmp(e.tag, "fail_score", int'(fail_score), e.fs);
      cmp(e.tag, "cfg_done", int'(cfg_done), e.cd);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(int which, logic v);
    case (which)
      0: btn_next    = v;
      1: btn_prev    = v;
      2: btn_inc     = v;
      3: btn_dec     = v;
      default: btn_confirm = v;
    endcase
  endtask

  // which: 0 next, 1 prev, 2 inc, 3 dec, 4 confirm
  task automatic press(int which, string tag);
    int cd = 0;
    set_btn(which, 1'b1);
    if (view == 3'd0) begin
      case (which)
        0: ms = (ms + 1) % 7;
        1: ms = (ms + 6) % 7;
        2: m_step(1'b1);
        3: m_step(1'b0);
        default: begin ms = 0; cd = 1; end
      endcase
    end
    push(tag, cd);
    tick();
    pop_check();
    set_btn(which, 1'b0);
    push({tag, "_rel"}, 0);
    tick();
    pop_check();
  endtask

  task automatic idle_check(string tag);
    push(tag, 0);
    tick();
    pop_check();
  endtask

  initial begin
    rst = 1'b0; view = 3'd0;
    btn_next = 1'b0; btn_prev = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_confirm = 1'b0;
    #2 rst = 1'b1;
    m_reset();
    push("reset", 0);
    #1 pop_check();
    tick();
    rst = 1'b0;
    idle_check("post_reset");

    // Navigate to answer_time and step it through its top wrap
    for (int i = 0; i < 3; i++) press(0, "next");
    for (int i = 0; i < 96; i++) begin
      press(2, "at_inc");
      if (i == 68) cmp("at_top", "time", int'(answer_time), 99);
      if (i == 69) cmp("at_wrap", "time", int'(answer_time), 5);
    end
    cmp("at_final", "state", int'(state), 3);
    cmp("at_final", "time", int'(answer_time), 31);

    // Player count wrap both ways, then fail_score low wrap
    press(1, "prev"); press(1, "prev");
    press(2, "pc_inc"); press(2, "pc_inc");
    cmp("pc_max", "player", int'(player_count), 4);
    press(2, "pc_wrap_up");
    cmp("pc_wrap_up", "player", int'(player_count), 1);
    press(3, "pc_wrap_dn");
    cmp("pc_wrap_dn", "player", int'(player_count), 4);
    press(1, "prev"); press(1, "prev");
    press(3, "fs_dec");
    press(3, "fs_wrap");
    cmp("fs_wrap", "fail_score", int'(fail_score), 9);

    // Auto-repeat on win_score: steps at press, +RD, +RD+RP, +RD+2RP
    press(1, "prev"); press(1, "prev");
    btn_inc = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 0 || i == RD || i == RD + RP || i == RD + 2 * RP) m_step(1'b1);
      push("hold", 0);
      tick();
      pop_check();
    end
    btn_inc = 1'b0;
    for (int i = 0; i < 8; i++) idle_check("hold_rel");
    cmp("hold_final", "win", int'(win_score), 14);

    // Simultaneous confirm + next + inc in state 2
    press(1, "prev"); press(1, "prev");
    btn_confirm = 1'b1; btn_next = 1'b1; btn_inc = 1'b1;
    ms = 0;
    push("combo", 1);
    tick();
    pop_check();
    btn_confirm = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
    push("combo_rel", 0);
    tick();
    pop_check();
    cmp("combo", "question", int'(question_count), 5);

    // view != 0 ignores presses; level already high when edits resume is not a press
    press(0, "next");
    view = 3'd1;
    press(0, "view_next");
    press(2, "view_inc");
    btn_inc = 1'b1;
    idle_check("view_hold");
    view = 3'd0;
    for (int i = 0; i < 3; i++) idle_check("view_back");
    btn_inc = 1'b0;
    idle_check("view_back_rel");
    press(2, "fresh_inc");
    cmp("fresh_inc", "player", int'(player_count), 1);

    // Asynchronous reset in the middle of a repeat hold
    btn_inc = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 0 || i == RD) m_step(1'b1);
      push("pre_rst_hold", 0);
      tick();
      pop_check();
    end
    #2 rst = 1'b1;
    m_reset();
    push("async_rst", 0);
    #1 pop_check();
    btn_inc = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < RD + 4; i++) idle_check("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
